// File: rtl/muldiv_sequencer_if.sv
// Handshake/result bundle between the EX-stage pipeline and the multiply/divide unit.
//   master : pipeline side, drives start/op/a/b/flush and observes busy/done/results.
//   slave  : multiply/divide unit side.
// Signals:
//   start        request, accepted only when idle and not flushed
//   op           00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b         operands, sampled with start
//   flush        abort any operation in flight
//   busy         unit not idle (stall request)
//   done         one-cycle pulse, hi/lo valid
//   div_by_zero  pulses with done for DIV/DIVU with b == 0
//   hi, lo       result pair
interface muldiv_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, flush,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative MIPS multiply/divide unit (MULT/MULTU/DIV/DIVU), one bit per cycle.
// Sequence: IDLE -> RUN (WIDTH steps) -> SIGN (sign fixup, load hi/lo) -> DONE -> IDLE.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  muldiv_sequencer_if slave modport (start/op/a/b/flush in, busy/done/div_by_zero/hi/lo out)
module muldiv_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input logic              clk,
  input logic              rst,
  muldiv_sequencer_if.slave bus
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StSign, StDone} state_e;

  state_e           state;
  logic [CntW-1:0]  cnt;
  logic             is_div;
  logic             neg_res;   // quotient / product sign
  logic             neg_rem;   // remainder sign (dividend sign, DIV only)
  logic             dz;
  logic [WIDTH-1:0] ma;        // |a|: multiplicand or dividend magnitude
  logic [WIDTH-1:0] mb;        // |b|: divisor magnitude (mul: used only to seed acc_lo)
  logic [WIDTH-1:0] acc_hi;    // partial product high / partial remainder
  logic [WIDTH-1:0] acc_lo;    // multiplier shifting out / quotient shifting in
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             done_q;
  logic             dz_q;

  // Operand magnitudes at acceptance; op[0]==0 means signed.
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  always_comb begin
    a_neg = ~bus.op[0] & bus.a[WIDTH-1];
    b_neg = ~bus.op[0] & bus.b[WIDTH-1];
    a_mag = a_neg ? -bus.a : bus.a;
    b_mag = b_neg ? -bus.b : bus.b;
  end

  // One iteration of shift-add multiply and restoring divide.
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;

  always_comb begin
    addend    = acc_lo[0] ? ma : '0;
    mul_sum   = {1'b0, acc_hi} + {1'b0, addend};
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, mb};
    // When div_ge holds the difference is < mb, so W-bit wraparound is exact.
    div_diff  = div_shift[WIDTH-1:0] - mb;
  end

  // Sign fixup.
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, dividend_raw;

  always_comb begin
    prod         = {acc_hi, acc_lo};
    prod_fix     = neg_res ? -prod : prod;
    quo_fix      = neg_res ? -acc_lo : acc_lo;
    rem_fix      = neg_rem ? -acc_hi : acc_hi;
    // Reconstructs the original dividend bit pattern from magnitude and sign.
    dividend_raw = neg_rem ? -ma : ma;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= StIdle;
      cnt     <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      dz      <= 1'b0;
      ma      <= '0;
      mb      <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      case (state)
        StIdle: begin
          if (bus.start && !bus.flush) begin
            is_div  <= bus.op[1];
            ma      <= a_mag;
            mb      <= b_mag;
            neg_res <= a_neg ^ b_neg;
            neg_rem <= bus.op[1] & a_neg;
            dz      <= bus.op[1] & (bus.b == '0);
            acc_hi  <= '0;
            acc_lo  <= bus.op[1] ? a_mag : b_mag;
            cnt     <= '0;
            state   <= StRun;
          end
        end
        StRun: begin
          if (bus.flush) begin
            state <= StIdle;
          end else begin
            if (is_div) begin
              acc_hi <= div_ge ? div_diff : div_shift[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
            end else begin
              acc_hi <= mul_sum[WIDTH:1];
              acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
            end
            cnt <= cnt + 1'b1;
            if (cnt == CntW'(WIDTH - 1)) state <= StSign;
          end
        end
        StSign: begin
          if (bus.flush) begin
            state <= StIdle;
          end else begin
            if (!is_div) begin
              hi_q <= prod_fix[2*WIDTH-1:WIDTH];
              lo_q <= prod_fix[WIDTH-1:0];
            end else if (dz) begin
              hi_q <= dividend_raw;
              lo_q <= '1;
            end else begin
              hi_q <= rem_fix;
              lo_q <= quo_fix;
            end
            done_q <= 1'b1;
            dz_q   <= dz;
            state  <= StDone;
          end
        end
        StDone:  state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

  assign bus.busy        = (state != StIdle);
  assign bus.done        = done_q;
  assign bus.div_by_zero = dz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  muldiv_sequencer_if #(.WIDTH(32)) bus ();

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Expected {div_by_zero, hi, lo}
  logic [64:0] exp_q[$];
  logic [64:0] e;

  int          acc_cyc;
  logic [31:0] done_hi, done_lo;
  logic        done_dz;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model from the arithmetic rules, using 64-bit host arithmetic.
  function automatic logic [64:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint          sa = $signed(a);
    longint          sb = $signed(b);
    longint unsigned ua = a;
    longint unsigned ub = b;
    longint          p, q, r;
    longint unsigned uq, ur;
    if (op == 2'b00) begin
      p = sa * sb;
      return {1'b0, p[63:0]};
    end
    if (op == 2'b01) begin
      uq = ua * ub;
      return {1'b0, uq[63:0]};
    end
    if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
    if (op == 2'b10) begin
      q = sa / sb;
      r = sa % sb;
      return {1'b0, r[31:0], q[31:0]};
    end
    uq = ua / ub;
    ur = ua % ub;
    return {1'b0, ur[31:0], uq[31:0]};
  endfunction

  // Monitor: every done pulse is matched against the scoreboard queue.
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 expected no done (t=%0t)", $time);
      end else begin
        e = exp_q.pop_front();
        chk("sb_hi", {32'd0, bus.hi}, {32'd0, e[63:32]});
        chk("sb_lo", {32'd0, bus.lo}, {32'd0, e[31:0]});
        chk("sb_dz", {63'd0, bus.div_by_zero}, {63'd0, e[64]});
      end
    end
    if (!rst && bus.div_by_zero && !bus.done) begin
      total++;
      bad++;
      $display("FAIL dz_without_done: got div_by_zero=1 done=0 expected done=1 (t=%0t)", $time);
    end
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit push);
    int guard = 0;
    @(negedge clk);
    while (bus.busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("idle_before_issue", {63'd0, bus.busy}, 64'd0);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    if (push) exp_q.push_back(model(op, a, b));
    @(posedge clk);
    #1;
    acc_cyc   = cyc;
    bus.start = 1'b0;
    chk("accepted", {63'd0, bus.busy}, 64'd1);
  endtask

  task automatic wait_done();
    bit seen    = 1'b0;
    bit busy_ok = 1'b1;
    int lat     = -1;
    for (int k = 0; k < 80 && !seen; k++) begin
      @(negedge clk);
      if (!bus.busy) busy_ok = 1'b0;
      if (bus.done) begin
        seen    = 1'b1;
        lat     = cyc - acc_cyc;
        done_hi = bus.hi;
        done_lo = bus.lo;
        done_dz = bus.div_by_zero;
      end
    end
    chk("done_seen", {63'd0, seen}, 64'd1);
    chk("latency", 64'(lat), 64'd33);
    chk("busy_until_done", {63'd0, busy_ok}, 64'd1);
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_done", {63'd0, bus.done}, 64'd0);
    chk("rst_dz", {63'd0, bus.div_by_zero}, 64'd0);
    chk("rst_hi", {32'd0, bus.hi}, 64'd0);
    chk("rst_lo", {32'd0, bus.lo}, 64'd0);

    // MULTU max * max
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_done();
    chk("multu_hi", {32'd0, done_hi}, 64'hFFFF_FFFE);
    chk("multu_lo", {32'd0, done_lo}, 64'h0000_0001);
    @(negedge clk);
    chk("busy_low_after_done", {63'd0, bus.busy}, 64'd0);

    issue(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b1);
    wait_done();
    chk("mult_hi", {32'd0, done_hi}, 64'hFFFF_FFFF);
    chk("mult_lo", {32'd0, done_lo}, 64'hFFFF_FFEB);

    issue(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_done();
    chk("div_lo", {32'd0, done_lo}, 64'hFFFF_FFFD);
    chk("div_hi", {32'd0, done_hi}, 64'hFFFF_FFFF);

    issue(2'b11, 32'd100, 32'd0, 1'b1);
    wait_done();
    chk("divz_lo", {32'd0, done_lo}, 64'hFFFF_FFFF);
    chk("divz_hi", {32'd0, done_hi}, 64'h0000_0064);
    chk("divz_flag", {63'd0, done_dz}, 64'd1);

    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_done();
    chk("ovf_lo", {32'd0, done_lo}, 64'h8000_0000);
    chk("ovf_hi", {32'd0, done_hi}, 64'd0);
    chk("ovf_flag", {63'd0, done_dz}, 64'd0);

    // DIVU 100/7 with a start attempt mid-operation that must be ignored.
    issue(2'b11, 32'd100, 32'd7, 1'b1);
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'b01;
    bus.a     = $urandom;
    bus.b     = $urandom;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("ignored_start_busy", {63'd0, bus.busy}, 64'd1);
    wait_done();
    chk("divu_hi", {32'd0, done_hi}, 64'd2);
    chk("divu_lo", {32'd0, done_lo}, 64'd14);

    // Back-to-back MULT in cycle after done, then flushed at cycle 10.
    issue(2'b00, $urandom, $urandom, 1'b0);
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    chk("flush_busy", {63'd0, bus.busy}, 64'd0);
    repeat (40) @(negedge clk);
    chk("flush_hi_kept", {32'd0, bus.hi}, 64'd2);
    chk("flush_lo_kept", {32'd0, bus.lo}, 64'd14);

    // start and flush together in IDLE: nothing accepted.
    @(negedge clk);
    bus.start = 1'b1;
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    chk("start_flush_busy", {63'd0, bus.busy}, 64'd0);

    // Reset at cycle 20 of a MULTU.
    issue(2'b01, $urandom, $urandom, 1'b0);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_busy", {63'd0, bus.busy}, 64'd0);
    chk("midrst_done", {63'd0, bus.done}, 64'd0);
    chk("midrst_hi", {32'd0, bus.hi}, 64'd0);
    chk("midrst_lo", {32'd0, bus.lo}, 64'd0);
    rst = 1'b0;
    issue(2'b01, 32'd12345, 32'd678, 1'b1);
    wait_done();

    // Randomized ops with biased corner operands.
    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0:       ra = 32'h8000_0000;
        1:       ra = 32'hFFFF_FFFF;
        2:       ra = $urandom_range(0, 20);
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = $urandom_range(1, 20);
        default: rb = $urandom;
      endcase
      issue(rop, ra, rb, 1'b1);
      wait_done();
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
